cnc_seg_feeder: RTL and testbench
=================================

Name: cnc_seg_feeder

Overview:
Host-side writer for the CNC interpolator's byte-buffer interface. Accepts a single-axis move command (signed total step count, max steps per period). Splits the command into per-period velocity bytes. Pushes each byte to the interpolator over the Nx/WR strobe interface, honouring the interpolator's flag_full backpressure. Sits between the command/host logic and the interpolator, in the same clock domain.

Parameters:
WR_HI, 2, cycles WR is held high per byte write (min 1)
WR_GAP, 3, cycles WR is held low after each write before flag_full is sampled again (min 2, covers the interpolator's one-cycle-late flag_full)
ACC, 8, velocity increment per byte when RAMP_EN is defined (1..127)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: latch total_steps/vmax and begin; ignored while busy=1
abort  in  1  level/pulse: cancel the move in progress
total_steps  in  16  signed two's-complement step count; sign gives direction
vmax  in  7  max steps per period; 0 is treated as 1
flag_full  in  1  interpolator buffer full (4 bytes held)
Nx  out  8  velocity byte: bit7 = direction (1 = negative), bits6:0 = magnitude
WR  out  1  write strobe; the interpolator captures Nx on the WR rising edge
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse when the last byte's WR_GAP completes

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; Nx=8'h00, WR=0, busy=0, done=0; internal remaining=0, dir=0. Reset has priority over start and abort, including mid-write.
- Latched on start: dir = total_steps[15]; remaining (17-bit) = |total_steps|, so -32768 gives 32768; vmax_eff = (vmax==0) ? 1 : vmax.
- States:
  - IDLE: busy=0. On start: go to DONE if total_steps==0, else go to LOAD.
  - LOAD: mag = min(remaining, v_cmd); Nx <= {dir, mag[6:0]}; remaining <= remaining - mag; go to CHECK. Without RAMP_EN, v_cmd = vmax_eff.
  - CHECK: if flag_full==0, WR <= 1 and go to WR_HIGH; else stay in CHECK with WR=0.
  - WR_HIGH: WR=1 for WR_HI cycles total, counted from the cycle WR is first seen high. Then WR <= 0 and go to WR_LOW.
  - WR_LOW: WR=0 for WR_GAP cycles. Then go to DONE if remaining==0, else go to LOAD.
  - DONE: done=1 for exactly one cycle; busy=0 in that cycle; go to IDLE.
- Timing rules:
  - Nx is stable at least one full cycle before WR rises, through the whole WR_HIGH phase, and until the next LOAD.
  - Latency from start (cycle t) to first WR rise is t+3 when flag_full=0.
  - Byte-to-byte WR rise spacing is WR_HI + WR_GAP + 2 cycles when not backpressured.
- Backpressure: flag_full is sampled only in CHECK. A byte is never written while flag_full=1. WR rises in the cycle after flag_full is seen low.
- Abort (any state except IDLE/DONE): next cycle WR=0, state=IDLE, busy=0, done not pulsed. Nx holds its value; remaining is cleared. start in the same cycle as abort is ignored.
- start while busy is ignored. start coincident with DONE is ignored.
- Only bytes with magnitude >= 1 are written; no trailing zero byte is sent.

Optional Feature:
RAMP_EN: when defined, velocity ramps up linearly.
- On start: v_cmd = min(ACC, vmax_eff).
- After each LOAD: v_cmd = min(v_cmd + ACC, vmax_eff), computed with saturation (no 7-bit wrap).
- Byte magnitude = min(remaining, v_cmd).
- No deceleration ramp.
When RAMP_EN is undefined, v_cmd = vmax_eff for every byte and the ACC logic is absent.

Test Plan:
- total_steps=300, vmax=100, flag_full=0 -> three WR rises with Nx=0x64, 0x64, 0x64; first rise 3 cycles after start; done pulses once; busy then drops.
- total_steps=-5, vmax=100 -> one write with Nx=0x85; done after WR_GAP.
- total_steps=0 -> no WR activity; done pulses 1 cycle after start.
- total_steps=250, vmax=50; flag_full=1 held from before the 2nd CHECK for 20 cycles -> Nx=0x32 stable and WR=0 throughout; WR rises 1 cycle after flag_full falls; 5 writes total.
- total_steps=1000, vmax=127; abort during the 3rd WR_HIGH -> WR=0 and busy=0 next cycle; no done; a new start is accepted next cycle; mid-move rst_n=0 clears all outputs.
- RAMP_EN, ACC=8, vmax=20, total_steps=40 -> Nx sequence 0x08, 0x10, 0x10; vmax=0, total_steps=2 without RAMP_EN -> 0x01, 0x01.

Source files
------------

// File: rtl/cnc_seg_feeder.sv
// -----------------------------------------------------------------------------
// cnc_seg_feeder
//
// Host-side writer for the CNC interpolator's byte buffer. A single-axis move
// (signed total step count, maximum steps per period) is split into
// per-period velocity bytes, and each byte is pushed to the interpolator over
// the Nx/WR strobe interface while honouring the flag_full backpressure.
// Same clock domain as the interpolator.
//
// Optional feature macro: RAMP_EN
//   undefined : every byte uses v_cmd = vmax_eff (ACC parameter not present)
//   defined   : v_cmd starts at min(ACC, vmax_eff) and grows by ACC after each
//               byte, saturating at vmax_eff (linear acceleration only)
//
// Parameters
//   WR_HI   cycles WR is held high per byte (>= 1)
//   WR_GAP  cycles WR is held low after each byte (>= 2, covers the
//           interpolator's one-cycle-late flag_full)
//   ACC     velocity increment per byte, 1..127 (RAMP_EN builds only)
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   start        in   pulse: latch total_steps/vmax and begin (ignored when busy
//                     or in the DONE cycle)
//   abort        in   cancel the move in progress
//   total_steps  in   [15:0] signed step count, sign gives direction
//   vmax         in   [6:0] max steps per period, 0 treated as 1
//   flag_full    in   interpolator buffer full
//   Nx           out  [7:0] {direction (1 = negative), magnitude[6:0]}
//   WR           out  write strobe, interpolator captures Nx on its rising edge
//   busy         out  high from the cycle after an accepted start until IDLE
//   done         out  one-cycle pulse after the last byte's gap completes
//
// Handshake: there is no ready/valid pair on the interpolator side. Nx is
// registered in LOAD, so it is stable for the whole CHECK cycle before WR
// rises and stays put through WR high and the following gap. flag_full is
// only looked at in CHECK; WR rises in the cycle after it is seen low, and the
// WR_GAP low time lets the interpolator's late flag_full settle before the
// next CHECK.
// -----------------------------------------------------------------------------
module cnc_seg_feeder #(
  parameter int WR_HI  = 2,
  parameter int WR_GAP = 3
`ifdef RAMP_EN
  ,
  parameter int ACC    = 8
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] total_steps,
  input  logic [6:0]  vmax,
  input  logic        flag_full,
  output logic [7:0]  Nx,
  output logic        WR,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CHECK   = 3'd2,
    S_WR_HIGH = 3'd3,
    S_WR_LOW  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Terminal values of the shared phase counter.
  localparam logic [7:0] HI_LAST  = 8'(WR_HI - 1);
  localparam logic [7:0] GAP_LAST = 8'(WR_GAP - 1);

`ifdef RAMP_EN
  localparam logic [6:0] ACC7 = 7'(ACC);
`endif

  // Registered state; state_q is the FSM state to probe when debugging.
  state_e      state_q, state_d;
  logic [7:0]  nx_q, nx_d;
  logic        wr_q, wr_d;
  logic        dir_q, dir_d;
  logic [16:0] rem_q, rem_d;
  logic [6:0]  veff_q, veff_d;
  logic [7:0]  cnt_q, cnt_d;
`ifdef RAMP_EN
  logic [6:0]  vcmd_q, vcmd_d;
  logic [7:0]  vcmd_sum;
  logic [6:0]  vcmd_init;
`endif

  // Command decode for the start cycle.
  logic [16:0] ts_ext;
  logic [16:0] ts_abs;
  logic [6:0]  veff_new;
  logic        ts_zero;

  // Per-byte magnitude for LOAD.
  logic [6:0]  v_cmd;
  logic [6:0]  mag;

  always_comb begin
    // Sign-extend to 17 bits first so that -32768 has a representable magnitude.
    ts_ext   = {total_steps[15], total_steps};
    ts_abs   = total_steps[15] ? (17'd0 - ts_ext) : ts_ext;
    veff_new = (vmax == 7'd0) ? 7'd1 : vmax;
    ts_zero  = (total_steps == 16'd0);
  end

`ifdef RAMP_EN
  always_comb begin
    vcmd_init = (ACC7 < veff_new) ? ACC7 : veff_new;
    // 8-bit sum so the increment saturates at vmax_eff instead of wrapping.
    vcmd_sum  = {1'b0, vcmd_q} + {1'b0, ACC7};
    v_cmd     = vcmd_q;
  end
`else
  always_comb begin
    v_cmd = veff_q;
  end
`endif

  always_comb begin
    mag = (rem_q < {10'd0, v_cmd}) ? rem_q[6:0] : v_cmd;
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    nx_d    = nx_q;
    wr_d    = wr_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    veff_d  = veff_q;
    cnt_d   = cnt_q;
`ifdef RAMP_EN
    vcmd_d  = vcmd_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          dir_d   = total_steps[15];
          rem_d   = ts_abs;
          veff_d  = veff_new;
`ifdef RAMP_EN
          vcmd_d  = vcmd_init;
`endif
          state_d = ts_zero ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        nx_d    = {dir_q, mag};
        rem_d   = rem_q - {10'd0, mag};
`ifdef RAMP_EN
        vcmd_d  = (vcmd_sum < {1'b0, veff_q}) ? vcmd_sum[6:0] : veff_q;
`endif
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (!flag_full) begin
          wr_d    = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_WR_HIGH;
        end
      end

      S_WR_HIGH: begin
        if (cnt_q == HI_LAST) begin
          wr_d    = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_WR_LOW;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end

      S_WR_LOW: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = (rem_q == 17'd0) ? S_DONE : S_LOAD;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        wr_d    = 1'b0;
      end
    endcase

    // Abort cancels an active move; Nx keeps whatever was last presented.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d = S_IDLE;
      nx_d    = nx_q;
      wr_d    = 1'b0;
      rem_d   = 17'd0;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nx_q    <= 8'h00;
      wr_q    <= 1'b0;
      dir_q   <= 1'b0;
      rem_q   <= 17'd0;
      veff_q  <= 7'd1;
      cnt_q   <= 8'd0;
`ifdef RAMP_EN
      vcmd_q  <= 7'd1;
`endif
    end else begin
      state_q <= state_d;
      nx_q    <= nx_d;
      wr_q    <= wr_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      veff_q  <= veff_d;
      cnt_q   <= cnt_d;
`ifdef RAMP_EN
      vcmd_q  <= vcmd_d;
`endif
    end
  end

  assign Nx   = nx_q;
  assign WR   = wr_q;
  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_cnc_seg_feeder.sv
// -----------------------------------------------------------------------------
// tb_cnc_seg_feeder
//
// Drives move commands into cnc_seg_feeder and compares Nx/WR/busy/done every
// cycle against a reference built from the move rules: the byte list is
// computed up front with plain arithmetic, and the timeline (CHECK cycle,
// WR rise, gap, done) is derived from the phase lengths and the flag_full
// values the bench itself applies.
// -----------------------------------------------------------------------------
module tb_cnc_seg_feeder;

  localparam int WR_HI  = 2;
  localparam int WR_GAP = 3;
  localparam int ACC    = 8;

  localparam int ACT_NONE  = 0;
  localparam int ACT_ABORT = 1;
  localparam int ACT_RESET = 2;

  localparam int FF_OFF    = 0;
  localparam int FF_RAND   = 1;
  localparam int FF_WINDOW = 2;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] total_steps;
  logic [6:0]  vmax;
  logic        flag_full;
  logic [7:0]  Nx;
  logic        WR;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  cnc_seg_feeder #(
    .WR_HI (WR_HI),
    .WR_GAP(WR_GAP)
`ifdef RAMP_EN
    ,
    .ACC   (ACC)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .total_steps(total_steps),
    .vmax       (vmax),
    .flag_full  (flag_full),
    .Nx         (Nx),
    .WR         (WR),
    .busy       (busy),
    .done       (done)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] exp_nx;
  int         n_cmp;
  int         n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic e_wr, input logic e_busy,
                             input logic e_done);
    chk({tag, ".Nx"},   {24'd0, Nx},   {24'd0, exp_nx});
    chk({tag, ".WR"},   {31'd0, WR},   {31'd0, e_wr});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
  endtask

  // Byte list for a move, straight from the splitting rules.
  task automatic build_bytes(input logic [15:0] ts, input logic [6:0] vm);
    int s;
    int left;
    int veff;
    int v;
    int m;
    exp_q.delete();
    s    = int'($signed(ts));
    left = (s < 0) ? -s : s;
    veff = (vm == 7'd0) ? 1 : int'(vm);
`ifdef RAMP_EN
    v = (ACC < veff) ? ACC : veff;
`else
    v = veff;
`endif
    while (left > 0) begin
      m = (left < v) ? left : v;
      exp_q.push_back({ts[15], 7'(m)});
      left -= m;
`ifdef RAMP_EN
      v = ((v + ACC) < veff) ? (v + ACC) : veff;
`endif
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Called at a negedge with the DUT idle. Cycle 0 carries the start pulse;
  // cycle n is observed at the negedge inside it, and the flag_full value
  // driven there is what the DUT samples at the end of that cycle.
  task automatic run_move(input string tag, input logic [15:0] ts, input logic [6:0] vm,
                          input int ff_mode, input int ff_lo, input int ff_hi,
                          input int act_at, input int act_kind);
    int  check_at;
    int  rise;
    int  done_at;
    bit  finished;
    bit  ff;
    logic e_wr;
    logic e_busy;
    logic e_done;

    build_bytes(ts, vm);
    check_at = 2;
    rise     = -100;
    done_at  = (exp_q.size() == 0) ? 1 : -1;
    finished = 1'b0;

    rst_n       = 1'b1;
    abort       = 1'b0;
    flag_full   = 1'b0;
    start       = 1'b1;
    total_steps = ts;
    vmax        = vm;
    @(negedge clk);

    for (int n = 1; n < 20000; n++) begin
      if (n == check_at && exp_q.size() > 0) exp_nx = exp_q[0];
      e_wr   = (n >= rise) && (n < rise + WR_HI);
      e_done = (n == done_at);
      e_busy = (done_at < 0) || (n < done_at);
      chk_outputs(tag, e_wr, e_busy, e_done);

      if (done_at >= 0 && n == done_at + 1) begin
        finished = 1'b1;
        break;
      end

      // Background stimulus: stray start pulses with junk operands must be
      // ignored while the move is busy and in its DONE cycle.
      case (ff_mode)
        FF_RAND:   ff = ($urandom_range(0, 2) == 0);
        FF_WINDOW: ff = (n >= ff_lo) && (n <= ff_hi);
        default:   ff = 1'b0;
      endcase
      flag_full   = ff;
      start       = ($urandom_range(0, 4) == 0);
      total_steps = 16'($urandom);
      vmax        = 7'($urandom);
      abort       = 1'b0;

      if (n == act_at && act_kind != ACT_NONE && (done_at < 0 || n < done_at)) begin
        start = 1'b1;
        abort = 1'b1;
        if (act_kind == ACT_RESET) begin
          rst_n  = 1'b0;
          exp_nx = 8'h00;
        end
        @(negedge clk);
        chk_outputs({tag, ".after_act"}, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        flag_full = 1'b0;
        finished = 1'b1;
        break;
      end

      if (exp_q.size() > 0 && n >= check_at && !ff) begin
        rise     = n + 1;
        void'(exp_q.pop_front());
        check_at = rise + WR_HI + WR_GAP + 1;
        if (exp_q.size() == 0) done_at = rise + WR_HI + WR_GAP;
      end
      @(negedge clk);
    end

    start = 1'b0;
    if (!finished) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s.timeout: observed no completion expected completion within budget", tag);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [15:0] r_ts;
    logic [6:0]  r_vm;
    int          r_mode;
    int          r_act;

    n_cmp       = 0;
    n_err       = 0;
    exp_nx      = 8'h00;
    rst_n       = 1'b0;
    start       = 1'b1;
    abort       = 1'b1;
    total_steps = 16'd300;
    vmax        = 7'd100;
    flag_full   = 1'b0;

    // Reset holds everything quiet even with start/abort asserted.
    repeat (3) @(negedge clk);
    chk_outputs("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk_outputs("post_reset_idle", 1'b0, 1'b0, 1'b0);

    // Directed moves.
    run_move("pos300_v100",  16'd300,   7'd100, FF_OFF,    0, 0,  0, ACT_NONE);
    run_move("neg5_v100",    -16'sd5,   7'd100, FF_OFF,    0, 0,  0, ACT_NONE);
    run_move("zero",         16'd0,     7'd100, FF_OFF,    0, 0,  0, ACT_NONE);
    run_move("bp250_v50",    16'd250,   7'd50,  FF_WINDOW, 8, 27, 0, ACT_NONE);
    // Third WR_HIGH begins at cycle 17 (rises at 3, 10, 17).
    run_move("abort1000",    16'd1000,  7'd127, FF_OFF,    0, 0, 17, ACT_ABORT);
    run_move("after_abort",  16'd40,    7'd20,  FF_OFF,    0, 0,  0, ACT_NONE);
    run_move("reset_mid",    16'd1000,  7'd127, FF_OFF,    0, 0, 12, ACT_RESET);
    run_move("vmax0",        16'd2,     7'd0,   FF_OFF,    0, 0,  0, ACT_NONE);
    run_move("min_neg",      16'h8000,  7'd127, FF_OFF,    0, 0,  0, ACT_NONE);
    run_move("abort_load",   16'd77,    7'd10,  FF_OFF,    0, 0,  1, ACT_ABORT);

    // Randomised moves with random backpressure and occasional abort.
    for (int k = 0; k < 24; k++) begin
      r_vm   = 7'($urandom_range(0, 127));
      r_ts   = 16'($urandom_range(0, (r_vm == 7'd0) ? 8 : int'(r_vm) * 6));
      if ($urandom_range(0, 1) == 1) r_ts = 16'd0 - r_ts;
      r_mode = $urandom_range(0, 1);
      r_act  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      run_move("random", r_ts, r_vm, r_mode, 0, 0, r_act,
               (r_act == 0) ? ACT_NONE : ACT_ABORT);
    end

    repeat (2) @(negedge clk);
    chk_outputs("final_idle", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
